// File: rtl/dp_collector_pkg.sv
// Shared constants for the distinguished-point collector.
// Optional per-entry walk-step tag: define DP_COLLECTOR_TAG_EN.
`ifndef R_Bits
`define R_Bits 110
`endif
`ifndef DP_Bits
`define DP_Bits 8
`endif

package dp_collector_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TAG_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dp_fifo.sv
// Circular FIFO: registered pointers, separate level count,
// combinational head read, room computed after same-cycle pop.
module dp_fifo #(
  parameter  int unsigned W     = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_i,
  output logic          room_o,
  output logic          valid_o,
  output logic [W-1:0]  rd_data_o,
  output logic [LW-1:0] level_o
);

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push;
  logic          pop;

  assign valid_o = (lvl_q != '0);
  assign pop     = rd_i & valid_o;
  assign room_o  = (lvl_q != LW'(DEPTH)) | pop;
  assign push    = wr_i & room_o;
  assign level_o = lvl_q;

  // Head forced to zero when empty so outputs read 0 after reset.
  assign rd_data_o = valid_o ? mem_q[rp_q] : '0;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    lvl_d = lvl_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q] <= wr_data_i;
  end

endmodule

// File: rtl/dp_collector.sv
// Filters walk points down to distinguished points and buffers them.
// Define DP_COLLECTOR_TAG_EN to add the out_tag walk-step tag.
module dp_collector
  import dp_collector_pkg::*;
#(
  parameter  int unsigned R_BITS  = `R_Bits,
  parameter  int unsigned DP_BITS = `DP_Bits,
  parameter  int unsigned DEPTH   = 8,
  localparam int unsigned LW      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [R_BITS-1:0] in_x,
  input  logic [R_BITS-1:0] in_y,
  input  logic              in_infinity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [R_BITS-1:0] out_x,
  output logic [R_BITS-1:0] out_y,
`ifdef DP_COLLECTOR_TAG_EN
  output logic [TAG_W-1:0]  out_tag,
`endif
  output logic [LW-1:0]     level,
  output logic [CNT_W-1:0]  dp_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

`ifdef DP_COLLECTOR_TAG_EN
  localparam int unsigned EW = 2 * R_BITS + TAG_W;
`else
  localparam int unsigned EW = 2 * R_BITS;
`endif

  logic              d1_q, d1_d;
  logic [R_BITS-1:0] x1_q, y1_q;
  logic [CNT_W-1:0]  dp_q, dp_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              room;
  logic [EW-1:0]     wr_data;
  logic [EW-1:0]     rd_data;

  assign d1_d = in_valid & ~in_infinity
              & (in_x[DP_BITS-1:0] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_q   <= 1'b0;
      x1_q   <= '0;
      y1_q   <= '0;
      dp_q   <= '0;
      drop_q <= '0;
    end else begin
      d1_q   <= d1_d;
      x1_q   <= in_x;
      y1_q   <= in_y;
      dp_q   <= dp_d;
      drop_q <= drop_d;
    end
  end

  always_comb begin
    dp_d   = dp_q;
    drop_d = drop_q;
    if (d1_q) begin
      dp_d = dp_q + 1'b1;
      if (!room) drop_d = sat_inc(drop_q);
    end
  end

`ifdef DP_COLLECTOR_TAG_EN
  logic             v1_q;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Tag counts every walk point, so it equals the step index mod 2^16.
  assign tag_d = v1_q ? tag_q + 1'b1 : tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      tag_q <= '0;
    end else begin
      v1_q  <= in_valid;
      tag_q <= tag_d;
    end
  end

  assign wr_data = {tag_q, y1_q, x1_q};
  assign out_tag = rd_data[2*R_BITS +: TAG_W];
`else
  assign wr_data = {y1_q, x1_q};
`endif

  dp_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_i      (d1_q),
    .wr_data_i (wr_data),
    .rd_i      (out_ready),
    .room_o    (room),
    .valid_o   (out_valid),
    .rd_data_o (rd_data),
    .level_o   (level)
  );

  assign out_x    = rd_data[0 +: R_BITS];
  assign out_y    = rd_data[R_BITS +: R_BITS];
  assign dp_cnt   = dp_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_dp_collector.sv
// Scoreboard bench for dp_collector: a cycle model predicts
// FIFO contents, counters and level; pops are compared in order.
module tb_dp_collector;
  import dp_collector_pkg::*;

  localparam int unsigned R     = `R_Bits;
  localparam int unsigned DPB   = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_infinity = 1'b0;
  logic         out_ready = 1'b0;
  logic [R-1:0] in_x = '0;
  logic [R-1:0] in_y = '0;
  logic         out_valid;
  logic [R-1:0] out_x;
  logic [R-1:0] out_y;
  logic [LW-1:0] level;
  logic [15:0]  dp_cnt;
  logic [15:0]  drop_cnt;
`ifdef DP_COLLECTOR_TAG_EN
  logic [15:0]  out_tag;
`endif

  always #5 clk = ~clk;

  dp_collector #(
    .R_BITS  (R),
    .DP_BITS (DPB),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_infinity (in_infinity),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
`ifdef DP_COLLECTOR_TAG_EN
    .out_tag     (out_tag),
`endif
    .level       (level),
    .dp_cnt      (dp_cnt),
    .drop_cnt    (drop_cnt)
  );

  typedef struct {
    logic [R-1:0] x;
    logic [R-1:0] y;
    logic [15:0]  tag;
  } ent_t;

  ent_t         sb[$];
  int           errs = 0;
  int           checks = 0;
  logic         s1_v, s1_d;
  logic [R-1:0] s1_x, s1_y;
  logic [15:0]  m_dp, m_drop, m_tag;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [R-1:0] rnd_pt(input bit dp);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[7:0] = dp ? 8'h00 : {r[7:1], 1'b1};
    return r[R-1:0];
  endfunction

  task automatic model_reset();
    sb.delete();
    s1_v   = 1'b0;
    s1_d   = 1'b0;
    s1_x   = '0;
    s1_y   = '0;
    m_dp   = '0;
    m_drop = '0;
    m_tag  = '0;
  endtask

  // Called at a negedge: check state, advance model, drive, clock.
  task automatic cyc(input bit v, input bit dp,
                     input bit inf, input bit rdy);
    logic [R-1:0] x, y;
    ent_t e;
    x = rnd_pt(dp);
    y = rnd_pt(1'b0);
    chk("out_valid", 128'(out_valid), 128'(sb.size() != 0));
    chk("level", 128'(level), 128'(sb.size()));
    chk("dp_cnt", 128'(dp_cnt), 128'(m_dp));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    if (rdy && sb.size() != 0) begin
      chk("out_x", 128'(out_x), 128'(sb[0].x));
      chk("out_y", 128'(out_y), 128'(sb[0].y));
`ifdef DP_COLLECTOR_TAG_EN
      chk("out_tag", 128'(out_tag), 128'(sb[0].tag));
`endif
      void'(sb.pop_front());
    end
    if (s1_v && s1_d) begin
      m_dp++;
      if (sb.size() < DEPTH) begin
        e.x = s1_x;
        e.y = s1_y;
        e.tag = m_tag;
        sb.push_back(e);
      end else if (m_drop != 16'hffff) begin
        m_drop++;
      end
    end
    if (s1_v) m_tag++;
    s1_v = v;
    s1_d = v && !inf && (x[DPB-1:0] == '0);
    s1_x = x;
    s1_y = y;
    in_valid    = v;
    in_x        = x;
    in_y        = y;
    in_infinity = inf;
    out_ready   = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    in_valid    = 1'b1;
    in_x        = rnd_pt(1'b1);
    in_y        = rnd_pt(1'b0);
    in_infinity = 1'b0;
    out_ready   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_level", 128'(level), 128'(0));
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_dp", 128'(dp_cnt), 128'(0));
      chk("rst_drop", 128'(drop_cnt), 128'(0));
      chk("rst_x", 128'(out_x), 128'(0));
      chk("rst_y", 128'(out_y), 128'(0));
`ifdef DP_COLLECTOR_TAG_EN
      chk("rst_tag", 128'(out_tag), 128'(0));
`endif
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // single distinguished point, latency and pop
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("single_dp", 128'(dp_cnt), 128'(1));
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("single_lvl", 128'(level), 128'(0));

    // filtering
    do_reset();
    repeat (100) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("filt_dp", 128'(dp_cnt), 128'(0));
    chk("filt_lvl", 128'(level), 128'(0));

    // overflow
    do_reset();
    repeat (10) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("ovf_lvl", 128'(level), 128'(8));
    chk("ovf_drop", 128'(drop_cnt), 128'(2));
    chk("ovf_dp", 128'(dp_cnt), 128'(10));

    // full with simultaneous push and pop across the wrap
    cyc(1, 1, 0, 0);
    repeat (20) cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1);
    chk("fpp_lvl", 128'(level), 128'(8));
    chk("fpp_drop", 128'(drop_cnt), 128'(2));
    chk("fpp_dp", 128'(dp_cnt), 128'(31));
    repeat (10) cyc(0, 0, 0, 1);
    chk("drain_lvl", 128'(level), 128'(0));

    // asynchronous reset mid-operation
    repeat (4) cyc(1, 1, 0, 0);
    in_valid = 1'b1;
    in_x     = rnd_pt(1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_lvl", 128'(level), 128'(0));
    chk("arst_dp", 128'(dp_cnt), 128'(0));
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    repeat (3) cyc(0, 0, 0, 0);

`ifdef DP_COLLECTOR_TAG_EN
    do_reset();
    for (int s = 0; s <= 70000; s++)
      cyc(1, (s == 5) || (s == 70000), 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("tag_first", 128'(out_tag), 128'(5));
    cyc(0, 0, 0, 1);
    chk("tag_second", 128'(out_tag), 128'(4464));
    cyc(0, 0, 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
